trng_ehr_fill: RTL and testbench
================================

# trng_ehr_fill

Entropy holding register (EHR) fill engine on the TRNG side of the TRNG→PRNG entropy interface. Sampled noise-source bits are shifted into an `EHR_WIDTH`-bit register, and every completed 32-bit word passes a continuous random number generator test (CRNGT). The block presents the full register as `trng_prng_ehr_data`/`trng_prng_ehr_valid`, and zeroizes and refills it when the PRNG pulses `prng_trng_ehr_rd`.

## Interface
- `EHR_WIDTH`, default 192: EHR width in bits. Must be a multiple of 32 and at least 64.
- `ERR_CNT_W`, default 8: width of the CRNGT failure counter.

Clock and reset:
- `rng_clk` in 1: the single clock. All state is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.

Inputs:
- `rnd_src_en` in 1: enables collection.
- `rnd_bit` in 1: sampled noise bit.
- `rnd_bit_valid` in 1: one-cycle strobe qualifying `rnd_bit`.
- `crngt_bypass` in 1: disables the CRNGT fail action. Debug only.
- `prng_trng_ehr_rd` in 1: one-cycle read/consume pulse from the PRNG.
- `err_cnt_clr` in 1: synchronous clear of `crngt_err_cnt`.

Outputs:
- `trng_prng_ehr_data` out `EHR_WIDTH`: EHR contents. Meaningful only while valid; zero otherwise.
- `trng_prng_ehr_valid` out 1: EHR full and unread.
- `trng_crngt_err` out 1: one-cycle pulse on a CRNGT failure.
- `crngt_err_cnt` out `ERR_CNT_W`: saturating count of CRNGT failures.
- `ehr_busy` out 1: state is FILL.

## Operation
States: IDLE, FILL, FULL. Reset enters IDLE.

Reset values of all outputs and internal state:
- Data, valid, err pulse, counter: 0.
- Bit counter: 0.
- `prev_word_vld`: 0.

IDLE:
- `rnd_src_en`=1 → FILL.

FILL:
- Each `rnd_bit_valid` shifts the bit in: `ehr <= {ehr[EHR_WIDTH-2:0], rnd_bit}`, then `bit_cnt++`. Bits are MSB-first, so the first word lands in `[EHR_WIDTH-1:EHR_WIDTH-32]`.
- When a strobe completes a 32-bit word (`bit_cnt[4:0]`==31), the new word `{ehr[30:0],rnd_bit}` is compared with `prev_word`. A failure requires all of:
  - `prev_word_vld`=1,
  - the words are equal,
  - `crngt_bypass`=0.
- On failure:
  - pulse `trng_crngt_err`, increment `crngt_err_cnt` (saturating),
  - zero the EHR and `bit_cnt`, stay in FILL.
- On every word completion, pass or fail, the new word is stored in `prev_word` and `prev_word_vld` is set to 1.
- The strobe completing bit `EHR_WIDTH` with a passing CRNGT → FULL.
- `rnd_src_en`=0 → IDLE, with EHR, `bit_cnt` and `prev_word_vld` cleared. This has priority over a simultaneous strobe, including one that would complete the fill.

FULL:
- Valid=1 and data is held stable.
- `rnd_bit_valid` is ignored (bits are dropped).
- `rnd_src_en` falling does not discard the data.
- `prng_trng_ehr_rd`=1:
  - valid←0, EHR←0, `bit_cnt`←0,
  - next state is FILL if `rnd_src_en`=1, else IDLE.
- `prev_word` is retained across reads, so the CRNGT is continuous across consecutive EHRs. It is invalidated only by reset or by an abort to IDLE.

Other rules:
- `prng_trng_ehr_rd` outside FULL is ignored.
- `err_cnt_clr` has priority over a simultaneous increment.
- `bit_cnt` width is clog2(`EHR_WIDTH`+1) and never wraps.

## Timing
- All outputs are registered. There are no combinational input→output paths.
- Valid rises on the edge that samples the final bit. It is visible in the cycle after that strobe.
- Read-to-empty latency is 1 cycle: valid and data are 0 in the cycle after the `rd` pulse.
- The earliest new strobe accepted after a read is in the cycle following the `rd` cycle.
- `trng_crngt_err` is high for exactly 1 cycle, the cycle after the failing strobe.
- Minimum fill time: `EHR_WIDTH` strobes. Back-to-back strobes are legal every cycle.
- Asserting `rst_n` low at any time (mid-fill or FULL) asynchronously forces the reset values listed under Operation.

## Structure
- Shared params include `trng_ehr_params.inc`:
  - state encodings (`TRNG_EHR_IDLE`=2'd0, `FILL`=2'd1, `FULL`=2'd2),
  - `CRNGT_WORD_W`=32.
- Sub-module `trng_crngt`:
  - holds `prev_word` and `prev_word_vld`,
  - takes the word-complete strobe, new word, bypass, and clear,
  - returns a registered fail flag.
- The top module holds the FSM, shifter, bit counter and error counter.

## Test plan
1. **Basic fill.** `EHR_WIDTH`=192, enable, then 192 back-to-back strobes carrying words 32'h00000001..32'h00000006 MSB-first.
   - Valid=1 one cycle after the last strobe.
   - Data = 192'h00000001_00000002_…_00000006.
   - `ehr_busy` drops.
2. **CRNGT failure and bypass.**
   - With bypass=0, send 32'hA5A5A5A5 twice. Required: err pulses once after strobe 64, `crngt_err_cnt`=1, `bit_cnt`=0. Valid rises only after 192 further strobes, and the first new word must differ from A5A5A5A5.
   - Repeat with bypass=1. Required: no error pulse, and valid rises after 192 strobes.
3. **Read and refill.** Pulse `rd` while valid.
   - Next cycle: valid=0, data=0.
   - Then 6 more words, the first equal to the last word of the previous EHR. Required: err pulse, which proves the CRNGT spans EHRs.
4. **Abort.** Drop `rnd_src_en` after 100 strobes.
   - Required: IDLE, data=0.
   - Re-enable and send a first word equal to the last pre-abort word. Required: no error, and valid after 192 strobes.
5. **Ignored inputs.**
   - Strobes in FULL: data unchanged.
   - `rd` in FILL: no effect.
   - `rnd_src_en`=0 while FULL: data held until `rd`, then IDLE.
6. **Reset and counter saturation.**
   - Assert `rst_n` low mid-fill (strobe 150). Required: all outputs 0 immediately; re-enabled fill needs 192 strobes.
   - Force 260 CRNGT failures. Required: `crngt_err_cnt`=255. Then `err_cnt_clr` asserted → 0.

Source files
------------

// File: rtl/trng_ehr_fill_pkg.sv
// Shared types and constants for the TRNG entropy holding register fill engine.
package trng_ehr_fill_pkg;

  localparam int unsigned CRNGT_WORD_W = 32;

  typedef enum logic [1:0] {
    TRNG_EHR_IDLE = 2'd0,
    TRNG_EHR_FILL = 2'd1,
    TRNG_EHR_FULL = 2'd2
  } trng_ehr_state_e;

  // True when the bit counter sits on the last bit of a CRNGT word.
  function automatic logic is_word_end(input logic [4:0] cnt_lsb);
    return cnt_lsb == 5'd31;
  endfunction

endpackage

// File: rtl/trng_ehr_fill_crngt.sv
// Continuous RNG test: remembers the previous 32-bit word and flags a repeat.
module trng_crngt
  import trng_ehr_fill_pkg::*;
(
  input  logic                    rng_clk,
  input  logic                    rst_n,
  input  logic                    word_done,
  input  logic [CRNGT_WORD_W-1:0] new_word,
  input  logic                    bypass,
  input  logic                    clr,
  output logic                    match,
  output logic                    fail
);

  logic [CRNGT_WORD_W-1:0] prev_word;
  logic                    prev_word_vld;

  // Qualified by word_done in the caller so the shifter can react on the same edge.
  assign match = prev_word_vld && (new_word == prev_word) && !bypass;

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_word     <= '0;
      prev_word_vld <= 1'b0;
      fail          <= 1'b0;
    end else begin
      fail <= word_done && match;
      if (clr) begin
        prev_word     <= '0;
        prev_word_vld <= 1'b0;
      end else if (word_done) begin
        prev_word     <= new_word;
        prev_word_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/trng_ehr_fill.sv
// EHR fill engine: shifts noise bits into the holding register, runs the CRNGT
// per 32-bit word and hands the full register to the PRNG.
module trng_ehr_fill
  import trng_ehr_fill_pkg::*;
#(
  parameter int unsigned EHR_WIDTH = 192,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 rng_clk,
  input  logic                 rst_n,
  input  logic                 rnd_src_en,
  input  logic                 rnd_bit,
  input  logic                 rnd_bit_valid,
  input  logic                 crngt_bypass,
  input  logic                 prng_trng_ehr_rd,
  input  logic                 err_cnt_clr,
  output logic [EHR_WIDTH-1:0] trng_prng_ehr_data,
  output logic                 trng_prng_ehr_valid,
  output logic                 trng_crngt_err,
  output logic [ERR_CNT_W-1:0] crngt_err_cnt,
  output logic                 ehr_busy
);

  localparam int unsigned CNT_W = $clog2(EHR_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(EHR_WIDTH - 1);

  trng_ehr_state_e         state_q, state_d;
  logic [EHR_WIDTH-1:0]    ehr_q, ehr_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [EHR_WIDTH-1:0]    data_q, data_d;
  logic                    valid_q, valid_d;
  logic [ERR_CNT_W-1:0]    err_cnt_q;
  logic                    strobe;
  logic                    word_done;
  logic                    crngt_match;
  logic                    crngt_fail;
  logic                    crngt_fail_q;
  logic                    crngt_clr;
  logic [CRNGT_WORD_W-1:0] new_word;

  // Abort (enable low) outranks a strobe in the same cycle.
  assign strobe     = (state_q == TRNG_EHR_FILL) && rnd_src_en && rnd_bit_valid;
  assign word_done  = strobe && is_word_end(bit_cnt_q[4:0]);
  assign new_word   = {ehr_q[CRNGT_WORD_W-2:0], rnd_bit};
  assign crngt_fail = word_done && crngt_match;

  trng_crngt u_crngt (
    .rng_clk   (rng_clk),
    .rst_n     (rst_n),
    .word_done (word_done),
    .new_word  (new_word),
    .bypass    (crngt_bypass),
    .clr       (crngt_clr),
    .match     (crngt_match),
    .fail      (crngt_fail_q)
  );

  always_comb begin
    state_d   = state_q;
    ehr_d     = ehr_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    crngt_clr = 1'b0;
    unique case (state_q)
      TRNG_EHR_IDLE: begin
        if (rnd_src_en) state_d = TRNG_EHR_FILL;
      end
      TRNG_EHR_FILL: begin
        if (!rnd_src_en) begin
          state_d   = TRNG_EHR_IDLE;
          ehr_d     = '0;
          bit_cnt_d = '0;
          crngt_clr = 1'b1;
        end else if (strobe) begin
          ehr_d     = {ehr_q[EHR_WIDTH-2:0], rnd_bit};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (crngt_fail) begin
            ehr_d     = '0;
            bit_cnt_d = '0;
          end else if (bit_cnt_q == LAST_BIT) begin
            state_d = TRNG_EHR_FULL;
            valid_d = 1'b1;
            data_d  = {ehr_q[EHR_WIDTH-2:0], rnd_bit};
          end
        end
      end
      TRNG_EHR_FULL: begin
        if (prng_trng_ehr_rd) begin
          state_d   = rnd_src_en ? TRNG_EHR_FILL : TRNG_EHR_IDLE;
          ehr_d     = '0;
          bit_cnt_d = '0;
          data_d    = '0;
          valid_d   = 1'b0;
        end
      end
      default: begin
        state_d   = TRNG_EHR_IDLE;
        ehr_d     = '0;
        bit_cnt_d = '0;
        data_d    = '0;
        valid_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TRNG_EHR_IDLE;
      ehr_q     <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ehr_q     <= ehr_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_cnt_clr) begin
      err_cnt_q <= '0;
    end else if (crngt_fail && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign trng_prng_ehr_data  = data_q;
  assign trng_prng_ehr_valid = valid_q;
  assign trng_crngt_err      = crngt_fail_q;
  assign crngt_err_cnt       = err_cnt_q;
  assign ehr_busy            = (state_q == TRNG_EHR_FILL);

endmodule

// File: tb/tb_trng_ehr_fill.sv
// Directed scoreboard bench for trng_ehr_fill at EHR_WIDTH=192.
module tb_trng_ehr_fill;

  localparam int unsigned W = 192;

  logic           rng_clk = 1'b0;
  logic           rst_n;
  logic           rnd_src_en;
  logic           rnd_bit;
  logic           rnd_bit_valid;
  logic           crngt_bypass;
  logic           prng_trng_ehr_rd;
  logic           err_cnt_clr;
  logic [W-1:0]   data;
  logic           valid;
  logic           err;
  logic [7:0]     err_cnt;
  logic           busy;

  int             n_vec = 0;
  int             n_err = 0;
  int             exp_cnt = 0;
  logic [W-1:0]   sb[$];
  logic [W-1:0]   last_ehr;
  logic [W-1:0]   v;

  trng_ehr_fill #(.EHR_WIDTH(W), .ERR_CNT_W(8)) dut (
    .rng_clk             (rng_clk),
    .rst_n               (rst_n),
    .rnd_src_en          (rnd_src_en),
    .rnd_bit             (rnd_bit),
    .rnd_bit_valid       (rnd_bit_valid),
    .crngt_bypass        (crngt_bypass),
    .prng_trng_ehr_rd    (prng_trng_ehr_rd),
    .err_cnt_clr         (err_cnt_clr),
    .trng_prng_ehr_data  (data),
    .trng_prng_ehr_valid (valid),
    .trng_crngt_err      (err),
    .crngt_err_cnt       (err_cnt),
    .ehr_busy            (busy)
  );

  always #5 rng_clk = ~rng_clk;

  task automatic tick();
    @(posedge rng_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sends v[n-1:0] MSB-first, one strobe per cycle.
  task automatic send_bits(input logic [W-1:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      rnd_bit = val[i];
      rnd_bit_valid = 1'b1;
      tick();
    end
    rnd_bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_bits({160'd0, w}, 32);
  endtask

  // Full fill with no CRNGT failures expected; rd_at>=0 also pulses rd mid-fill.
  task automatic send_ehr(input logic [W-1:0] val, input int rd_at);
    logic [W-1:0] exp;
    sb.push_back(val);
    for (int i = W - 1; i >= 0; i--) begin
      rnd_bit = val[i];
      rnd_bit_valid = 1'b1;
      prng_trng_ehr_rd = (i == rd_at);
      tick();
      if (i == rd_at) chk("rd_in_fill_busy", {191'd0, busy}, 1);
      if (i % 32 == 0 && i != 0) chk("no_err_word", {191'd0, err}, 0);
      if (i == 1) chk("valid_early", {191'd0, valid}, 0);
    end
    rnd_bit_valid = 1'b0;
    prng_trng_ehr_rd = 1'b0;
    chk("valid_after_fill", {191'd0, valid}, 1);
    chk("busy_after_fill", {191'd0, busy}, 0);
    chk("err_after_fill", {191'd0, err}, 0);
    chk("cnt_after_fill", {184'd0, err_cnt}, W'(exp_cnt));
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL sb_empty: observed empty expected entry");
    end else begin
      exp = sb.pop_front();
      chk("ehr_data", data, exp);
      last_ehr = exp;
    end
  endtask

  task automatic read_ehr(input logic en_after);
    prng_trng_ehr_rd = 1'b1;
    tick();
    prng_trng_ehr_rd = 1'b0;
    chk("rd_valid", {191'd0, valid}, 0);
    chk("rd_data", data, 0);
    chk("rd_busy", {191'd0, busy}, W'(en_after));
  endtask

  initial begin
    rst_n = 1'b0;
    rnd_src_en = 1'b0;
    rnd_bit = 1'b0;
    rnd_bit_valid = 1'b0;
    crngt_bypass = 1'b0;
    prng_trng_ehr_rd = 1'b0;
    err_cnt_clr = 1'b0;
    #12;
    chk("rst_data", data, 0);
    chk("rst_valid", {191'd0, valid}, 0);
    chk("rst_err", {191'd0, err}, 0);
    chk("rst_cnt", {184'd0, err_cnt}, 0);
    chk("rst_busy", {191'd0, busy}, 0);
    rst_n = 1'b1;
    tick();

    // Basic fill
    rnd_src_en = 1'b1;
    tick();
    chk("busy_fill", {191'd0, busy}, 1);
    send_ehr({32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6}, -1);

    // Strobes while FULL are dropped
    send_bits(W'(32'h3FF), 10);
    chk("full_hold_data", data, last_ehr);
    chk("full_hold_valid", {191'd0, valid}, 1);

    // Read, then CRNGT spanning EHRs
    read_ehr(1'b1);
    send_word(32'h6);
    exp_cnt++;
    chk("span_err_pulse", {191'd0, err}, 1);
    chk("span_err_cnt", {184'd0, err_cnt}, W'(exp_cnt));
    tick();
    chk("span_err_1cyc", {191'd0, err}, 0);
    send_ehr({32'h7, 32'h8, 32'h9, 32'hA, 32'hB, 32'hC}, -1);

    // Repeated word failure
    read_ehr(1'b1);
    send_word(32'hA5A5A5A5);
    chk("a5_first_ok", {191'd0, err}, 0);
    send_word(32'hA5A5A5A5);
    exp_cnt++;
    chk("a5_err_pulse", {191'd0, err}, 1);
    chk("a5_err_cnt", {184'd0, err_cnt}, W'(exp_cnt));
    send_ehr({32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16}, -1);

    // Bypass: repeat tolerated
    read_ehr(1'b1);
    crngt_bypass = 1'b1;
    send_ehr({32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1, 32'h2, 32'h3, 32'h4}, -1);
    crngt_bypass = 1'b0;

    // rd during FILL ignored
    read_ehr(1'b1);
    send_ehr({32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26}, 150);

    // Enable low while FULL keeps data until read, then IDLE
    rnd_src_en = 1'b0;
    tick();
    tick();
    chk("en_low_full_valid", {191'd0, valid}, 1);
    chk("en_low_full_data", data, last_ehr);
    read_ehr(1'b0);
    tick();
    chk("idle_after_rd", {191'd0, busy}, 0);

    // Abort after 100 strobes; abort outranks the simultaneous strobe
    rnd_src_en = 1'b1;
    tick();
    v = {32'h31, 32'h32, 32'h33, 32'h34, 32'h35, 32'h36};
    send_bits(v >> 92, 100);
    rnd_src_en = 1'b0;
    rnd_bit_valid = 1'b1;
    tick();
    rnd_bit_valid = 1'b0;
    chk("abort_busy", {191'd0, busy}, 0);
    chk("abort_data", data, 0);
    chk("abort_valid", {191'd0, valid}, 0);
    rnd_src_en = 1'b1;
    tick();
    send_ehr({32'h33, 32'h41, 32'h42, 32'h43, 32'h44, 32'h45}, -1);

    // Async reset mid-fill
    read_ehr(1'b1);
    send_bits(W'(150'h2AAAA_5555_1234_ABCD_0F0F_F0F0_77), 150);
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("amid_data", data, 0);
    chk("amid_valid", {191'd0, valid}, 0);
    chk("amid_err", {191'd0, err}, 0);
    chk("amid_cnt", {184'd0, err_cnt}, 0);
    chk("amid_busy", {191'd0, busy}, 0);
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    send_ehr({32'h51, 32'h52, 32'h53, 32'h54, 32'h55, 32'h56}, -1);

    // Counter saturation
    read_ehr(1'b1);
    for (int k = 0; k < 261; k++) begin
      send_word(32'hDEADBEEF);
      if (k > 0 && exp_cnt < 255) exp_cnt++;
    end
    chk("sat_err_pulse", {191'd0, err}, 1);
    chk("sat_cnt", {184'd0, err_cnt}, W'(exp_cnt));
    chk("sat_cnt_255", {184'd0, err_cnt}, 255);

    // Clear wins over a simultaneous failure
    send_bits(W'(32'hDEADBEEF >> 1), 31);
    err_cnt_clr = 1'b1;
    send_bits(W'(1), 1);
    err_cnt_clr = 1'b0;
    exp_cnt = 0;
    chk("clr_prio_err", {191'd0, err}, 1);
    chk("clr_prio_cnt", {184'd0, err_cnt}, 0);
    send_word(32'hDEADBEEF);
    exp_cnt++;
    chk("cnt_after_clr", {184'd0, err_cnt}, W'(exp_cnt));
    err_cnt_clr = 1'b1;
    tick();
    err_cnt_clr = 1'b0;
    chk("clr_cnt", {184'd0, err_cnt}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
